cpu_inst_fifo: RTL and testbench

//  Instruction queue between the fetch stage and the two decode slots (a, b).
//  - Accepts 0-2 fetched instructions per cycle and presents the oldest two to ID.
//  - Retires 0-2 entries per cycle, as directed by the ID inst_taken handshake.
//  - Decouples fetch bandwidth from dual-issue decode.
//  - Flushed on branch redirect and on exception.

---
 rtl/cpu_inst_fifo_pkg.sv | 15 +
 rtl/cpu_inst_fifo_ptr.sv | 39 +++
 rtl/cpu_inst_fifo.sv | 66 ++++++
 tb/tb_cpu_inst_fifo.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cpu_inst_fifo_pkg.sv
// cpu_inst_fifo_pkg: shared types for the fetch-to-decode instruction queue
package cpu_inst_fifo_pkg;
  localparam int INST_FIFO_DEPTH = 16;
  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] code;
  } except_info_t;
  typedef struct packed {
    inst_addr_t   pc;
    inst_t        inst;
    except_info_t except;
  } fetch_entry_t;
endpackage

// File: rtl/cpu_inst_fifo_ptr.sv
// cpu_inst_fifo_ptr: head/tail/count bookkeeping with push drop and pop clamping
module cpu_inst_fifo_ptr #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [1:0]    push_valid,
  input  logic          pop_a,
  input  logic          pop_b,
  output logic [AW-1:0] head,
  output logic [AW-1:0] tail,
  output logic [AW:0]   count,
  output logic          push_ok,
  output logic          full
);
  logic [1:0]  n_push, n_pop_raw, n_pop, n_acc;
  logic [AW:0] free;
  assign n_push    = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};
  assign free      = (AW+1)'(DEPTH) - count;
  // free is judged on the pre-pop count: a slot freed this cycle is not reusable yet
  assign push_ok   = (n_push != 2'd0) && ((AW+1)'(n_push) <= free);
  assign n_acc     = push_ok ? n_push : 2'd0;
  assign n_pop_raw = {1'b0, pop_a} + {1'b0, pop_a & pop_b};
  assign n_pop     = ((AW+1)'(n_pop_raw) > count) ? count[1:0] : n_pop_raw;
  assign full      = free < (AW+1)'(2);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_pop);
      tail  <= tail + AW'(n_acc);
      count <= count + (AW+1)'(n_acc) - (AW+1)'(n_pop);
    end
  end
endmodule

// File: rtl/cpu_inst_fifo.sv
// cpu_inst_fifo: 2-in/2-out instruction queue between fetch and dual decode slots
module cpu_inst_fifo
  import cpu_inst_fifo_pkg::*;
#(
  parameter int DEPTH = INST_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             push_valid,
  input  inst_addr_t   [1:0]     push_pc,
  input  inst_t        [1:0]     push_inst,
  input  except_info_t [1:0]     push_except,
  output logic                   full,
  output logic                   valid_a,
  output inst_addr_t             pc_a,
  output inst_t                  inst_a,
  output except_info_t           except_a,
  output logic                   valid_b,
  output inst_addr_t             pc_b,
  output inst_t                  inst_b,
  output except_info_t           except_b,
  input  logic                   pop_a,
  input  logic                   pop_b
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] head, tail, head1, tail1;
  logic [AW:0]   count;
  logic          push_ok;
  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  e0, e1, ea, eb;
  cpu_inst_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .pop_a      (pop_a),
    .pop_b      (pop_b),
    .head       (head),
    .tail       (tail),
    .count      (count),
    .push_ok    (push_ok),
    .full       (full)
  );
  assign head1 = head + AW'(1);
  assign tail1 = tail + AW'(1);
  assign e1 = '{pc: push_pc[1], inst: push_inst[1], except: push_except[1]};
  // a lone younger slot is compacted down to the tail position
  assign e0 = push_valid[0] ? '{pc: push_pc[0], inst: push_inst[0], except: push_except[0]} : e1;
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= e0;
      if (&push_valid) mem[tail1] <= e1;
    end
  end
  assign ea       = mem[head];
  assign eb       = mem[head1];
  assign valid_a  = count != '0;
  assign valid_b  = count > (AW+1)'(1);
  assign pc_a     = valid_a ? ea.pc : '0;
  assign inst_a   = valid_a ? ea.inst : '0;
  assign except_a = valid_a ? ea.except : '0;
  assign pc_b     = valid_b ? eb.pc : '0;
  assign inst_b   = valid_b ? eb.inst : '0;
  assign except_b = valid_b ? eb.except : '0;
endmodule

// File: tb/tb_cpu_inst_fifo.sv
// tb_cpu_inst_fifo: scoreboard bench for the fetch-to-decode instruction queue
module tb_cpu_inst_fifo;
  import cpu_inst_fifo_pkg::*;
  logic clk = 0, rst = 1, flush = 0, pop_a = 0, pop_b = 0;
  logic [1:0] push_valid = 0;
  inst_addr_t   [1:0] push_pc = '0;
  inst_t        [1:0] push_inst = '0;
  except_info_t [1:0] push_except = '0;
  logic full, valid_a, valid_b;
  inst_addr_t pc_a, pc_b;
  inst_t inst_a, inst_b;
  except_info_t except_a, except_b;
  int tests = 0, fails = 0, seq = 0;
  fetch_entry_t sb[$];
  cpu_inst_fifo dut (
    .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid),
    .push_pc(push_pc), .push_inst(push_inst), .push_except(push_except),
    .full(full), .valid_a(valid_a), .pc_a(pc_a), .inst_a(inst_a), .except_a(except_a),
    .valid_b(valid_b), .pc_b(pc_b), .inst_b(inst_b), .except_b(except_b),
    .pop_a(pop_a), .pop_b(pop_b)
  );
  always #5 clk = ~clk;
  function automatic fetch_entry_t mk(input int k);
    fetch_entry_t e;
    e.pc          = 32'h8000_0000 + 32'(k) * 4;
    e.inst        = 32'h1300_0013 ^ (32'(k) << 7);
    e.except.valid = (k % 5) == 3;
    e.except.code  = 5'(k);
    return e;
  endfunction
  // drives one cycle of stimulus and advances the reference model
  task automatic step(input logic [1:0] pv, input logic pa, input logic pb, input logic fl);
    fetch_entry_t e0, e1;
    int np, nq;
    bit ok;
    e0 = mk(seq); e1 = mk(seq + 1); seq += 2;
    push_valid = pv; pop_a = pa; pop_b = pb; flush = fl;
    push_pc = {e1.pc, e0.pc}; push_inst = {e1.inst, e0.inst}; push_except = {e1.except, e0.except};
    np = int'(pv[0]) + int'(pv[1]);
    nq = pa ? (pb ? 2 : 1) : 0;
    if (nq > sb.size()) nq = sb.size();
    ok = np <= 16 - sb.size();
    @(posedge clk);
    if (fl) sb.delete();
    else begin
      repeat (nq) void'(sb.pop_front());
      if (ok && pv[0]) sb.push_back(e0);
      if (ok && pv[1]) sb.push_back(e1);
    end
    @(negedge clk);
    push_valid = 0; pop_a = 0; pop_b = 0; flush = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0; sb.delete(); seq = 0;
    tests += 5;
    if (valid_a !== 1'b0) begin fails++; $display("FAIL reset_valid_a got %b want 0", valid_a); end
    if (valid_b !== 1'b0) begin fails++; $display("FAIL reset_valid_b got %b want 0", valid_b); end
    if (pc_a !== 32'h0) begin fails++; $display("FAIL reset_pc_a got %h want 0", pc_a); end
    if (inst_a !== 32'h0) begin fails++; $display("FAIL reset_inst_a got %h want 0", inst_a); end
    if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
  endtask
  // pops everything, checking each head against the scoreboard and the entry total
  task automatic test_drain(input string tag, input int want_n);
    int n = 0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      tests += 2;
      if (valid_a !== 1'b1 || pc_a !== sb[0].pc || inst_a !== sb[0].inst || except_a !== sb[0].except) begin
        fails++; $display("FAIL %s_drain_a got v=%b pc=%h inst=%h ex=%h want pc=%h inst=%h ex=%h",
          tag, valid_a, pc_a, inst_a, except_a, sb[0].pc, sb[0].inst, sb[0].except);
      end
      if (valid_b !== (sb.size() >= 2) || pc_b !== (sb.size() >= 2 ? sb[1].pc : 32'h0)) begin
        fails++; $display("FAIL %s_drain_b got v=%b pc=%h want v=%b", tag, valid_b, pc_b, sb.size() >= 2);
      end
      n += (sb.size() >= 2) ? 2 : 1;
      step(2'b00, 1, 1, 0);
    end
    tests += 2;
    if (n !== want_n) begin fails++; $display("FAIL %s_drain_count got %0d want %0d", tag, n, want_n); end
    if (valid_a !== 1'b0) begin fails++; $display("FAIL %s_drain_empty got valid_a=%b want 0", tag, valid_a); end
  endtask
  task automatic test_push_two;
    step(2'b11, 0, 0, 0);
    tests += 4;
    if (valid_a !== 1'b1 || valid_b !== 1'b1) begin fails++; $display("FAIL push2_valid got %b%b want 11", valid_a, valid_b); end
    if (pc_a !== 32'h8000_0000) begin fails++; $display("FAIL push2_pc_a got %h want 80000000", pc_a); end
    if (pc_b !== 32'h8000_0004) begin fails++; $display("FAIL push2_pc_b got %h want 80000004", pc_b); end
    if (inst_b !== sb[1].inst) begin fails++; $display("FAIL push2_inst_b got %h want %h", inst_b, sb[1].inst); end
    test_drain("push2", 2);
  endtask
  task automatic test_full;
    repeat (7) step(2'b11, 0, 0, 0);
    step(2'b01, 0, 0, 0);
    tests++;
    if (full !== 1'b1) begin fails++; $display("FAIL full_at15 got %b want 1", full); end
    step(2'b11, 0, 0, 0);
    step(2'b01, 1, 0, 0);
    tests++;
    if (full !== 1'b1) begin fails++; $display("FAIL full_after_swap got %b want 1", full); end
    test_drain("full", 15);
  endtask
  task automatic test_pop_clamp;
    step(2'b01, 0, 0, 0);
    step(2'b00, 1, 1, 0);
    tests++;
    if (valid_a !== 1'b0) begin fails++; $display("FAIL clamp_empty got valid_a=%b want 0", valid_a); end
    step(2'b11, 0, 0, 0);
    step(2'b01, 0, 0, 0);
    step(2'b00, 0, 1, 0);
    tests++;
    if (pc_a !== sb[0].pc) begin fails++; $display("FAIL popb_alone got pc_a=%h want %h", pc_a, sb[0].pc); end
    test_drain("clamp", 3);
  endtask
  task automatic test_wrap;
    test_reset();
    repeat (15) begin step(2'b01, 0, 0, 0); step(2'b00, 1, 0, 0); end
    step(2'b11, 0, 0, 0);
    tests += 2;
    if (pc_b !== pc_a + 32'd4) begin fails++; $display("FAIL wrap_contig got pc_a=%h pc_b=%h want pc_b=pc_a+4", pc_a, pc_b); end
    if (pc_a !== sb[0].pc) begin fails++; $display("FAIL wrap_pc_a got %h want %h", pc_a, sb[0].pc); end
    step(2'b10, 0, 0, 0);
    test_drain("wrap", 3);
  endtask
  task automatic test_flush;
    step(2'b11, 0, 0, 0); step(2'b11, 0, 0, 0); step(2'b01, 0, 0, 0);
    step(2'b11, 1, 0, 1);
    tests += 3;
    if (valid_a !== 1'b0 || valid_b !== 1'b0) begin fails++; $display("FAIL flush_valid got %b%b want 00", valid_a, valid_b); end
    if (pc_a !== 32'h0) begin fails++; $display("FAIL flush_pc_a got %h want 0", pc_a); end
    if (full !== 1'b0) begin fails++; $display("FAIL flush_full got %b want 0", full); end
    step(2'b01, 0, 0, 0);
    tests++;
    if (valid_a !== 1'b1 || valid_b !== 1'b0 || pc_a !== sb[0].pc) begin
      fails++; $display("FAIL flush_repush got v=%b%b pc=%h want 10 pc=%h", valid_a, valid_b, pc_a, sb[0].pc);
    end
    test_drain("flush", 1);
  endtask
  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom_range(0, 29) == 0);
      tests++;
      if (valid_a !== (sb.size() >= 1) || valid_b !== (sb.size() >= 2) || full !== (sb.size() > 14) ||
          pc_a !== (sb.size() >= 1 ? sb[0].pc : 32'h0) || inst_b !== (sb.size() >= 2 ? sb[1].inst : 32'h0)) begin
        fails++; $display("FAIL random_%0d got v=%b%b full=%b pc_a=%h inst_b=%h want size=%0d",
          i, valid_a, valid_b, full, pc_a, inst_b, sb.size());
      end
    end
    test_drain("random", sb.size());
  endtask
  initial begin
    test_reset();
    test_push_two();
    test_full();
    test_pop_clamp();
    test_wrap();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
